// File: rtl/qsip_cfg_sequencer.sv
// AXI4-Lite config sequencer: writes the masked registers in index order, reads them back and compares.
// Latency: start to done is 2 cycles for an empty mask; each AXI channel waits on its ready/valid with one transfer outstanding.
module qsip_cfg_sequencer #(
   parameter int                            C_M_AXI_ADDR_WIDTH = 32,
   parameter int                            C_M_AXI_DATA_WIDTH = 32,
   parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = '0
) (
   input  logic                              ACLK,
   input  logic                              ARESETN,

   input  logic                              start,
   input  logic [4*C_M_AXI_DATA_WIDTH-1:0]   cfg_data,
   input  logic [3:0]                        cfg_mask,
   output logic                              busy,
   output logic                              done,
   output logic                              error,
   output logic [1:0]                        err_idx,
   output logic [1:0]                        err_code,

   output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
   output logic [2:0]                        m_axi_awprot,
   output logic                              m_axi_awvalid,
   input  logic                              m_axi_awready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
   output logic                              m_axi_wvalid,
   input  logic                              m_axi_wready,
   input  logic [1:0]                        m_axi_bresp,
   input  logic                              m_axi_bvalid,
   output logic                              m_axi_bready,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
   output logic [2:0]                        m_axi_arprot,
   output logic                              m_axi_arvalid,
   input  logic                              m_axi_arready,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
   input  logic [1:0]                        m_axi_rresp,
   input  logic                              m_axi_rvalid,
   output logic                              m_axi_rready
);

   localparam int AW = C_M_AXI_ADDR_WIDTH;
   localparam int DW = C_M_AXI_DATA_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_REQ,
      S_WR_RESP,
      S_RD_REQ,
      S_RD_RESP,
      S_DONE
   } state_t;

   state_t              r_state;
   logic [4*DW-1:0]     r_cfg_data;
   logic [3:0]          r_mask;
   logic [1:0]          r_idx;
   logic                r_aw_ok;
   logic                r_w_ok;
   logic                r_busy;
   logic                r_done;
   logic                r_error;
   logic [1:0]          r_err_idx;
   logic [1:0]          r_err_code;
   logic [AW-1:0]       r_awaddr;
   logic                r_awvalid;
   logic [DW-1:0]       r_wdata;
   logic [DW/8-1:0]     r_wstrb;
   logic                r_wvalid;
   logic                r_bready;
   logic [AW-1:0]       r_araddr;
   logic                r_arvalid;
   logic                r_rready;

   function automatic logic [1:0] f_lowest(input logic [3:0] mask);
      logic [1:0] res;
      res = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (mask[i]) res = i[1:0];
      end
      return res;
   endfunction

   function automatic logic [AW-1:0] f_addr(input logic [1:0] idx);
      return C_BASE_ADDR + {{(AW-4){1'b0}}, idx, 2'b00};
   endfunction

   logic [1:0]    w_first_in;
   logic [1:0]    w_first_lat;
   logic [3:0]    w_above;
   logic          w_next_vld;
   logic [1:0]    w_next_idx;
   logic [DW-1:0] w_in_word;
   logic [DW-1:0] w_next_word;
   logic [DW-1:0] w_cur_word;
   logic          w_aw_hs;
   logic          w_w_hs;
   logic          w_wr_fin;

   // Bits strictly above the current index: shifting 4'b1110 drops idx and everything below it.
   assign w_above     = r_mask & (4'b1110 << r_idx);
   assign w_next_vld  = |w_above;
   assign w_next_idx  = f_lowest(w_above);
   assign w_first_in  = f_lowest(cfg_mask);
   assign w_first_lat = f_lowest(r_mask);
   assign w_in_word   = cfg_data[DW*w_first_in +: DW];
   assign w_next_word = r_cfg_data[DW*w_next_idx +: DW];
   assign w_cur_word  = r_cfg_data[DW*r_idx +: DW];
   assign w_aw_hs     = r_awvalid & m_axi_awready;
   assign w_w_hs      = r_wvalid & m_axi_wready;
   assign w_wr_fin    = (r_aw_ok | w_aw_hs) & (r_w_ok | w_w_hs);

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_state    <= S_IDLE;
         r_cfg_data <= '0;
         r_mask     <= '0;
         r_idx      <= '0;
         r_aw_ok    <= 1'b0;
         r_w_ok     <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_err_idx  <= '0;
         r_err_code <= '0;
         r_awaddr   <= '0;
         r_awvalid  <= 1'b0;
         r_wdata    <= '0;
         r_wstrb    <= '0;
         r_wvalid   <= 1'b0;
         r_bready   <= 1'b0;
         r_araddr   <= '0;
         r_arvalid  <= 1'b0;
         r_rready   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_cfg_data <= cfg_data;
                  r_mask     <= cfg_mask;
                  r_error    <= 1'b0;
                  r_err_idx  <= '0;
                  r_err_code <= '0;
                  r_busy     <= 1'b1;
                  if (|cfg_mask) begin
                     r_idx     <= w_first_in;
                     r_awaddr  <= f_addr(w_first_in);
                     r_wdata   <= w_in_word;
                     r_wstrb   <= '1;
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                     r_aw_ok   <= 1'b0;
                     r_w_ok    <= 1'b0;
                     r_state   <= S_WR_REQ;
                  end else begin
                     r_state <= S_DONE;
                  end
               end
            end

            // Address and data channels retire independently; move on once both have.
            S_WR_REQ: begin
               if (w_aw_hs) begin
                  r_awvalid <= 1'b0;
                  r_aw_ok   <= 1'b1;
               end
               if (w_w_hs) begin
                  r_wvalid <= 1'b0;
                  r_w_ok   <= 1'b1;
               end
               if (w_wr_fin) begin
                  r_bready <= 1'b1;
                  r_state  <= S_WR_RESP;
               end
            end

            S_WR_RESP: begin
               if (m_axi_bvalid) begin
                  r_bready <= 1'b0;
                  if (m_axi_bresp != 2'b00) begin
                     r_error    <= 1'b1;
                     r_err_code <= 2'b01;
                     r_err_idx  <= r_idx;
                     r_state    <= S_DONE;
                  end else if (w_next_vld) begin
                     r_idx     <= w_next_idx;
                     r_awaddr  <= f_addr(w_next_idx);
                     r_wdata   <= w_next_word;
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                     r_aw_ok   <= 1'b0;
                     r_w_ok    <= 1'b0;
                     r_state   <= S_WR_REQ;
                  end else begin
                     r_idx     <= w_first_lat;
                     r_araddr  <= f_addr(w_first_lat);
                     r_arvalid <= 1'b1;
                     r_state   <= S_RD_REQ;
                  end
               end
            end

            S_RD_REQ: begin
               if (m_axi_arready) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= S_RD_RESP;
               end
            end

            // A bad response code takes precedence over a data mismatch.
            S_RD_RESP: begin
               if (m_axi_rvalid) begin
                  r_rready <= 1'b0;
                  if (m_axi_rresp != 2'b00) begin
                     r_error    <= 1'b1;
                     r_err_code <= 2'b10;
                     r_err_idx  <= r_idx;
                     r_state    <= S_DONE;
                  end else if (m_axi_rdata != w_cur_word) begin
                     r_error    <= 1'b1;
                     r_err_code <= 2'b11;
                     r_err_idx  <= r_idx;
                     r_state    <= S_DONE;
                  end else if (w_next_vld) begin
                     r_idx     <= w_next_idx;
                     r_araddr  <= f_addr(w_next_idx);
                     r_arvalid <= 1'b1;
                     r_state   <= S_RD_REQ;
                  end else begin
                     r_state <= S_DONE;
                  end
               end
            end

            S_DONE: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy          = r_busy;
   assign done          = r_done;
   assign error         = r_error;
   assign err_idx       = r_err_idx;
   assign err_code      = r_err_code;
   assign m_axi_awaddr  = r_awaddr;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_awvalid = r_awvalid;
   assign m_axi_wdata   = r_wdata;
   assign m_axi_wstrb   = r_wstrb;
   assign m_axi_wvalid  = r_wvalid;
   assign m_axi_bready  = r_bready;
   assign m_axi_araddr  = r_araddr;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_arvalid = r_arvalid;
   assign m_axi_rready  = r_rready;

endmodule
